// File: rtl/uart_mmio_bridge_if.sv
// CPU load/store bus as seen by the UART MMIO bridge.
// The master drives the request; the slave answers with registered read data.
interface uart_mmio_bridge_if;
   logic        i_sel;
   logic        i_we;
   logic [3:0]  i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_rvalid;

   modport master (output i_sel, i_we, i_addr, i_wdata, input o_rdata, o_rvalid);
   modport slave  (input i_sel, i_we, i_addr, i_wdata, output o_rdata, o_rvalid);
endinterface

// File: rtl/uart_mmio_bridge.sv
// Register front-end between the CPU bus and the uart stream ports.
// Provides TX/RX FIFOs, sticky error flags and a level interrupt.
module uart_mmio_bridge #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_mmio_bridge_if.slave     bus,
   output logic                  o_irq,
   output logic [DATA_WIDTH-1:0] o_uart_data,
   output logic                  o_uart_valid,
   input  logic                  i_uart_ready,
   input  logic [DATA_WIDTH-1:0] i_uart_data,
   input  logic                  i_uart_valid,
   output logic                  o_uart_ready,
   input  logic                  i_tx_busy,
   input  logic                  i_rx_busy,
   input  logic                  i_rx_overrun,
   input  logic                  i_rx_frame
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      REG_TXDATA = 2'd0,
      REG_RXDATA = 2'd1,
      REG_STATUS = 2'd2,
      REG_IRQEN  = 2'd3
   } reg_e;

   logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
   logic [AW:0]           r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [1:0]            r_irqen;
   logic                  r_rx_overrun, r_rx_frame, r_tx_drop;
   logic [31:0]           r_rdata;
   logic                  r_rvalid;
   logic                  r_irq;

   reg_e                  w_reg;
   logic                  w_bus_wr, w_bus_rd;
   logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_tx_drop_set, w_w1c;
   logic [AW:0]           w_tx_wp_nxt, w_tx_rp_nxt, w_rx_wp_nxt, w_rx_rp_nxt;
   logic [1:0]            w_irqen_nxt;
   logic                  w_ovr_nxt, w_frm_nxt, w_drop_nxt;
   logic                  w_irq_nxt;
   logic [DATA_WIDTH-1:0] w_tx_head, w_rx_head;
   logic [31:0]           w_status, w_rd_mux;
   logic                  w_unused;

   assign w_reg    = reg_e'(bus.i_addr[3:2]);
   assign w_bus_wr = bus.i_sel &  bus.i_we;
   assign w_bus_rd = bus.i_sel & ~bus.i_we;
   assign w_unused = ^{bus.i_addr[1:0], bus.i_wdata[31:DATA_WIDTH]};

   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
   assign w_rx_empty = (r_rx_wp == r_rx_rp);
   assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);

   // A store to a full TX FIFO is dropped even if the uart pops in the same cycle.
   assign w_tx_push     = w_bus_wr && (w_reg == REG_TXDATA) && !w_tx_full;
   assign w_tx_drop_set = w_bus_wr && (w_reg == REG_TXDATA) &&  w_tx_full;
   assign w_tx_pop      = !w_tx_empty && i_uart_ready;
   assign w_rx_push     = i_uart_valid && !w_rx_full;
   assign w_rx_pop      = w_bus_rd && (w_reg == REG_RXDATA) && !w_rx_empty;
   assign w_w1c         = w_bus_wr && (w_reg == REG_STATUS);

   assign w_tx_wp_nxt = w_tx_push ? r_tx_wp + PTR_ONE : r_tx_wp;
   assign w_tx_rp_nxt = w_tx_pop  ? r_tx_rp + PTR_ONE : r_tx_rp;
   assign w_rx_wp_nxt = w_rx_push ? r_rx_wp + PTR_ONE : r_rx_wp;
   assign w_rx_rp_nxt = w_rx_pop  ? r_rx_rp + PTR_ONE : r_rx_rp;

   assign w_irqen_nxt = (w_bus_wr && (w_reg == REG_IRQEN)) ? bus.i_wdata[1:0] : r_irqen;
   assign w_ovr_nxt   = i_rx_overrun  | (r_rx_overrun & ~(w_w1c & bus.i_wdata[6]));
   assign w_frm_nxt   = i_rx_frame    | (r_rx_frame   & ~(w_w1c & bus.i_wdata[7]));
   assign w_drop_nxt  = w_tx_drop_set | (r_tx_drop    & ~(w_w1c & bus.i_wdata[8]));
   assign w_irq_nxt   = (w_irqen_nxt[0] & (w_rx_wp_nxt != w_rx_rp_nxt))
                      | (w_irqen_nxt[1] & (w_tx_wp_nxt == w_tx_rp_nxt));

   assign w_tx_head = r_tx_mem[r_tx_rp[AW-1:0]];
   assign w_rx_head = r_rx_mem[r_rx_rp[AW-1:0]];
   assign w_status  = 32'({r_tx_drop, r_rx_frame, r_rx_overrun, i_rx_busy, i_tx_busy,
                           w_rx_empty, w_rx_full, w_tx_empty, w_tx_full});

   always_comb begin
      w_rd_mux = '0;
      unique case (w_reg)
         REG_TXDATA: w_rd_mux = '0;
         REG_RXDATA: w_rd_mux = w_rx_empty ? 32'h8000_0000 : 32'(w_rx_head);
         REG_STATUS: w_rd_mux = w_status;
         REG_IRQEN:  w_rd_mux = 32'(r_irqen);
         default:    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.i_wdata[DATA_WIDTH-1:0];
      if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= i_uart_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_wp      <= '0;
         r_tx_rp      <= '0;
         r_rx_wp      <= '0;
         r_rx_rp      <= '0;
         r_irqen      <= '0;
         r_rx_overrun <= 1'b0;
         r_rx_frame   <= 1'b0;
         r_tx_drop    <= 1'b0;
         r_rdata      <= '0;
         r_rvalid     <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_tx_wp      <= w_tx_wp_nxt;
         r_tx_rp      <= w_tx_rp_nxt;
         r_rx_wp      <= w_rx_wp_nxt;
         r_rx_rp      <= w_rx_rp_nxt;
         r_irqen      <= w_irqen_nxt;
         r_rx_overrun <= w_ovr_nxt;
         r_rx_frame   <= w_frm_nxt;
         r_tx_drop    <= w_drop_nxt;
         r_rvalid     <= w_bus_rd;
         if (w_bus_rd) r_rdata <= w_rd_mux;
         r_irq        <= w_irq_nxt;
      end
   end

   assign bus.o_rdata  = r_rdata;
   assign bus.o_rvalid = r_rvalid;
   assign o_irq        = r_irq;
   assign o_uart_valid = !w_tx_empty;
   assign o_uart_data  = w_tx_empty ? '0 : w_tx_head;
   assign o_uart_ready = !w_rx_full;
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge; bus reads are checked through a
// scoreboard queue popped by an independent monitor on o_rvalid.
module tb_uart_mmio_bridge;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       o_irq;
   logic [7:0] o_uart_data;
   logic       o_uart_valid;
   logic       i_uart_ready = 1'b0;
   logic [7:0] i_uart_data  = '0;
   logic       i_uart_valid = 1'b0;
   logic       o_uart_ready;
   logic       i_tx_busy = 1'b0, i_rx_busy = 1'b0, i_rx_overrun = 1'b0, i_rx_frame = 1'b0;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] exp_q[$];

   uart_mmio_bridge_if bus ();

   uart_mmio_bridge #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .o_irq(o_irq),
      .o_uart_data(o_uart_data), .o_uart_valid(o_uart_valid), .i_uart_ready(i_uart_ready),
      .i_uart_data(i_uart_data), .i_uart_valid(i_uart_valid), .o_uart_ready(o_uart_ready),
      .i_tx_busy(i_tx_busy), .i_rx_busy(i_rx_busy),
      .i_rx_overrun(i_rx_overrun), .i_rx_frame(i_rx_frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.o_rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid: got 0x%08h expected no response", bus.o_rdata);
         end else begin
            check("rdata", bus.o_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = a; bus.i_wdata = d;
      @(negedge clk);
      bus.i_sel = 1'b0; bus.i_we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_we = 1'b0; bus.i_addr = a;
      exp_q.push_back(exp);
      @(negedge clk);
      bus.i_sel = 1'b0;
   endtask

   task automatic uart_push(input logic [7:0] d);
      @(negedge clk);
      i_uart_valid = 1'b1; i_uart_data = d;
      @(negedge clk);
      i_uart_valid = 1'b0;
   endtask

   task automatic ready_pulse();
      @(negedge clk);
      i_uart_ready = 1'b1;
      @(negedge clk);
      i_uart_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_sel = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_rdata", bus.o_rdata, 32'h0);
      check("rst_rvalid", 32'(bus.o_rvalid), 32'h0);
      check("rst_uart_ready", 32'(o_uart_ready), 32'h1);
      check("rst_uart_valid", 32'(o_uart_valid), 32'h0);
      check("rst_uart_data", 32'(o_uart_data), 32'h0);
      check("rst_irq", 32'(o_irq), 32'h0);
      rst = 1'b1;
      bus_read(4'h8, 32'h0000_000A);

      // TX basic path
      bus_write(4'h0, 32'h41);
      bus_write(4'h0, 32'h42);
      check("tx_valid", 32'(o_uart_valid), 32'h1);
      check("tx_head0", 32'(o_uart_data), 32'h41);
      ready_pulse();
      check("tx_head1", 32'(o_uart_data), 32'h42);
      ready_pulse();
      check("tx_valid_empty", 32'(o_uart_valid), 32'h0);
      check("tx_data_empty", 32'(o_uart_data), 32'h0);
      bus_read(4'h8, 32'h0000_000A);
      bus_read(4'h0, 32'h0);

      // TX overflow: 17th byte dropped, drain shows first 16
      for (int i = 0; i < 17; i++) bus_write(4'h0, 32'(8'h10 + i));
      bus_read(4'h8, 32'h0000_0109);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("drain_valid", 32'(o_uart_valid), 32'h1);
         check("drain_data", 32'(o_uart_data), 32'(8'h10 + i));
         i_uart_ready = 1'b1;
      end
      @(negedge clk);
      i_uart_ready = 1'b0;
      check("drain_done", 32'(o_uart_valid), 32'h0);
      bus_read(4'h8, 32'h0000_010A);
      bus_write(4'h8, 32'h100);
      bus_read(4'h8, 32'h0000_000A);

      // RX path
      bus_write(4'h4, 32'h55);
      bus_read(4'h4, 32'h8000_0000);
      uart_push(8'h5A);
      bus_read(4'h4, 32'h0000_005A);
      bus_read(4'h4, 32'h8000_0000);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         i_uart_valid = 1'b1; i_uart_data = 8'(8'h60 + i);
      end
      @(negedge clk);
      i_uart_data = 8'hEE;
      check("rx_full_ready", 32'(o_uart_ready), 32'h0);
      repeat (2) @(negedge clk);
      check("rx_full_hold", 32'(o_uart_ready), 32'h0);
      i_uart_valid = 1'b0;
      bus_read(4'h8, 32'h0000_0006);
      bus_read(4'h4, 32'h0000_0060);
      check("rx_ready_after_read", 32'(o_uart_ready), 32'h1);
      for (int i = 1; i < 16; i++) bus_read(4'h4, 32'(8'h60 + i));
      bus_read(4'h4, 32'h8000_0000);

      // empty read racing a uart push
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_we = 1'b0; bus.i_addr = 4'h4;
      i_uart_valid = 1'b1; i_uart_data = 8'h77;
      exp_q.push_back(32'h8000_0000);
      @(negedge clk);
      bus.i_sel = 1'b0; i_uart_valid = 1'b0;
      bus_read(4'h4, 32'h0000_0077);

      // interrupt
      bus_write(4'hC, 32'h1);
      bus_read(4'hC, 32'h1);
      check("irq_idle", 32'(o_irq), 32'h0);
      uart_push(8'h33);
      check("irq_after_push", 32'(o_irq), 32'h1);
      @(negedge clk);
      check("irq_hold", 32'(o_irq), 32'h1);
      bus_read(4'h4, 32'h0000_0033);
      check("irq_after_read", 32'(o_irq), 32'h0);
      bus_write(4'hC, 32'h2);
      check("irq_tx_empty", 32'(o_irq), 32'h1);
      bus_write(4'hC, 32'hFFFF_FFF0);
      check("irq_off", 32'(o_irq), 32'h0);
      bus_read(4'hC, 32'h0);

      // sticky flags: set wins over same-cycle clear
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = 4'h8; bus.i_wdata = 32'h80;
      i_rx_frame = 1'b1;
      @(negedge clk);
      bus.i_sel = 1'b0; bus.i_we = 1'b0; i_rx_frame = 1'b0;
      bus_read(4'h8, 32'h0000_008A);
      @(negedge clk);
      i_rx_overrun = 1'b1; i_tx_busy = 1'b1; i_rx_busy = 1'b1;
      @(negedge clk);
      i_rx_overrun = 1'b0;
      bus_read(4'h8, 32'h0000_00FA);
      i_tx_busy = 1'b0; i_rx_busy = 1'b0;
      bus_write(4'h8, 32'hC0);
      bus_read(4'h8, 32'h0000_000A);

      // asynchronous reset mid-transfer with a read in flight
      bus_write(4'h0, 32'h99);
      check("pre_rst_valid", 32'(o_uart_valid), 32'h1);
      check("pre_rst_data", 32'(o_uart_data), 32'h99);
      @(negedge clk);
      bus.i_sel = 1'b1; bus.i_we = 1'b0; bus.i_addr = 4'h8;
      #1 rst = 1'b0;
      #1;
      check("arst_uart_valid", 32'(o_uart_valid), 32'h0);
      check("arst_uart_data", 32'(o_uart_data), 32'h0);
      check("arst_uart_ready", 32'(o_uart_ready), 32'h1);
      check("arst_irq", 32'(o_irq), 32'h0);
      check("arst_rdata", bus.o_rdata, 32'h0);
      @(negedge clk);
      bus.i_sel = 1'b0;
      check("arst_rvalid", 32'(bus.o_rvalid), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      bus_read(4'h8, 32'h0000_000A);
      check("post_rst_valid", 32'(o_uart_valid), 32'h0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
